tick_counter_display: RTL

//  Parametrised free-running display counter: prescaler divides CLK_50A to a tick, an N-digit
//  hex/BCD up/down counter advances per tick, per-digit 7-seg patterns drive board HEX displays.

---
 rtl/quatro_disp_pkg.sv | 24 ++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/tick_counter_display.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/quatro_disp_pkg.sv
// Shared types, segment constants and glyph table for the tick counter display.
// Segment encoding: active low, bit0 = a .. bit6 = g.
package quatro_disp_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_ZERO  = 7'h40;

    // Glyphs 0-9, A, b, C, d, E, F
    localparam seg_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // A digit above 9 is treated as 9 when counting in BCD
    function automatic digit_t bcd_clamp(input digit_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to active-low 7-segment pattern decoder.
module seg7_hex_decoder
    import quatro_disp_pkg::*;
(
    input  digit_t digit,
    output seg_t   seg
);

    assign seg = SEG_HEX[digit];

endmodule

// File: rtl/tick_counter_display.sv
// Free-running N-digit hex/BCD up/down counter advanced by a prescaled tick,
// with run/pause, clear, load, rollover flag and per-digit 7-segment outputs.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (digit 0 always shown).
module tick_counter_display
    import quatro_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 40
)
(
    input  logic                    CLK_50A,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    dir_up,
    input  logic                    mode_bcd,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic                    tick,
    output logic                    wrap
);

    localparam int VW  = 4 * NUM_DIGITS;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0]         presc;
    logic [VW:0]           step_res;   // {rolled, next value}
    logic [NUM_DIGITS-1:0] blank;

    // Hex step: plain binary +/-1; the extra MSB is the carry/borrow out
    function automatic logic [VW:0] hex_step(input logic [VW-1:0] v, input logic up);
        logic [VW:0] r;
        if (up)
            r = {1'b0, v} + (VW+1)'(1);
        else
            r = {1'b0, v} - (VW+1)'(1);
        return r;
    endfunction

    // BCD step: per-digit ripple, digits above 9 clamped to 9 first
    function automatic logic [VW:0] bcd_step(input logic [VW-1:0] v, input logic up);
        logic [VW-1:0] r;
        logic          c;
        digit_t        d;
        r = '0;
        c = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = bcd_clamp(v[4*k +: 4]);
            if (c) begin
                if (up) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[4*k +: 4] = d;
        end
        return {c, r};
    endfunction

    // Tick is decoded from the prescaler phase and gated by run so a paused
    // prescaler sitting at terminal count never steps the value
    assign tick = run && (presc == TERM);

    // Prescaler: advances only while running, clear restarts the period
    always_ff @(posedge CLK_50A) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (run) begin
            presc <= (presc == TERM) ? '0 : presc + 1'b1;
        end
    end

    // Next-value candidate for the current mode and direction
    always_comb begin
        step_res = '0;
        if (mode_bcd)
            step_res = bcd_step(value, dir_up);
        else
            step_res = hex_step(value, dir_up);
    end

    // Count register and rollover flag: clear > load > tick step > hold
    always_ff @(posedge CLK_50A) begin
        if (!reset_n) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= load_val;
            wrap  <= 1'b0;
        end else if (tick) begin
            value <= step_res[VW-1:0];
            wrap  <= step_res[VW];
        end else begin
            wrap  <= 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_seen;

    // Blank every digit above the most significant nonzero digit
    always_comb begin
        lz_seen = 1'b0;
        blank   = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            if (value[4*k +: 4] != 4'd0)
                lz_seen = 1'b1;
            blank[k] = ~lz_seen;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg_t dec;

        seg7_hex_decoder u_dec (
            .digit (value[4*k +: 4]),
            .seg   (dec)
        );

        assign segs[7*k +: 7] = blank[k] ? SEG_BLANK : dec;
    end

endmodule
